core_lsu: RTL and testbench
===========================

Name: core_lsu

Overview:
- Load/store unit that sits downstream of the EX stage and consumes its results: the ALU result is the effective address and the forwarded rs2 value is the store data.
- Drives a request/grant/response data-memory interface, stalls the pipeline while a transaction is in flight, and returns sign- or zero-extended load data to the WB stage.
- Single clock domain. Handles one outstanding transaction at a time.

Parameters:
- XLEN, 32, datapath, address and data width (only 32 is supported).

Ports:
- i_clk  in  1  core clock, rising edge.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- i_valid  in  1  EX/MEM register holds a valid instruction.
- i_opcode  in  7  opcode; 0000011 = LOAD, 0100011 = STORE, anything else is ignored.
- i_funct3  in  3  access size and sign.
- i_rd  in  5  load destination register.
- i_addr  in  XLEN  effective address (EX ALU result).
- i_store_data  in  XLEN  store data (EX forwarded rs2).
- o_stall  out  1  freeze IF..MEM pipeline registers.
- o_dmem_req  out  1  memory request.
- o_dmem_we  out  1  1 = write.
- o_dmem_addr  out  XLEN  word-aligned address ({addr[31:2], 2'b00}).
- o_dmem_be  out  4  byte enables.
- o_dmem_wdata  out  XLEN  lane-replicated write data.
- i_dmem_gnt  in  1  request accepted.
- i_dmem_rvalid  in  1  response valid (sent for both loads and stores).
- i_dmem_rdata  in  XLEN  read word.
- o_load_valid  out  1  one-cycle pulse: load result ready.
- o_load_data  out  XLEN  extended load result.
- o_load_rd  out  5  destination register of the completed load.
- o_misaligned  out  1  one-cycle pulse: misaligned access, no request issued.

Behaviour:
- mem_op = i_valid & (opcode == LOAD or STORE).
- Misalignment check: misaligned = halfword with addr[0]=1, or word with addr[1:0]!=0.
- States:
  - IDLE: on mem_op & !misaligned, latch addr, be, wdata, we, funct3 and rd, then go to REQ.
  - IDLE: on mem_op & misaligned, pulse o_misaligned the next cycle, stay in IDLE, no stall.
  - REQ: o_dmem_req=1 with latched fields held stable. On i_dmem_gnt go to RESP. req is held until gnt; there is no timeout.
  - RESP: req=0. On i_dmem_rvalid go to IDLE. For a load, o_load_data, o_load_rd and o_load_valid=1 are registered the cycle after rvalid.
- Stall:
  - o_stall = (IDLE & mem_op & !misaligned) | REQ | (RESP & !i_dmem_rvalid).
  - o_stall is combinational and falls in the rvalid cycle, so the pipeline advances at that edge.
  - Minimum load/store occupancy is 3 cycles (IDLE, REQ with same-cycle gnt, RESP with same-cycle rvalid).
- Store formatting:
  - SB (000): be = 1<<addr[1:0], wdata = {4{d[7:0]}}.
  - SH (001): be = addr[1] ? 1100 : 0011, wdata = {2{d[15:0]}}.
  - SW (010): be = 1111.
  - Loads: be = 1111, we = 0.
- Load extraction: select the byte or halfword lane by latched addr[1:0].
  - LB 000 / LH 001 sign-extend.
  - LBU 100 / LHU 101 zero-extend.
  - LW 010 passes the word through.
- Undefined funct3 (load 011/110/111, store 011..111) executes as a word access with the alignment check applied.
- rvalid and gnt are ignored in states that do not expect them.
- Reset (async, any state):
  - Returns to IDLE; all outputs 0 (req, we, be, addr, wdata, stall, load_valid, load_data, load_rd, misaligned).
  - A response arriving after reset is dropped because the unit is in IDLE.
- Non-memory instructions pass without a stall and without any memory activity.

Decomposition:
- Shared package (core_pkg):
  - OPCODE_LOAD / OPCODE_STORE localparams.
  - funct3 size encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - lsu_state_e enum {IDLE, REQ, RESP}.
- One combinational sub-module, lsu_load_align (rdata, addr[1:0], funct3 -> extended data), reusable by a future misaligned-split path.
- Store formatting stays inline.

Test Plan:
- SB, addr 0x1003, data 0x000000A5; gnt same cycle, rvalid next:
  - be=1000, wdata=0xA5A5A5A5, dmem_addr=0x1000, we=1.
  - Stall for 3 cycles; no load_valid.
- LH, addr 0x2002, rdata 0x8001_1234:
  - o_load_data=0xFFFF8001 the cycle after rvalid; LHU same access -> 0x00008001.
  - LB, addr 0x2001, rdata 0x0000_9A00 -> 0xFFFFFF9A.
- LW, addr 0x3000; gnt withheld 4 cycles, rvalid after 2 more:
  - req, addr and be stable throughout; stall high until the rvalid cycle.
  - load_rd matches i_rd.
- LW at 0x3002 and SH at 0x3001:
  - o_misaligned pulses once each.
  - No o_dmem_req, no stall.
- Deassert i_rst_n while in RESP, then raise a stray rvalid:
  - All outputs 0 and state IDLE.
  - No load_valid from the stray rvalid.
- Back-to-back SW then LW, and ADD (opcode 0110011) with i_valid=1:
  - Both memory transactions issue sequentially with correct stalls.
  - The ADD causes no req and no stall.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the core pipeline: memory opcodes, funct3 access
// encodings, LSU state and access-size helpers.
package core_pkg;

  localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } lsu_state_e;

  typedef enum logic [1:0] {
    SIZE_B,
    SIZE_H,
    SIZE_W
  } lsu_size_e;

  // Access width from funct3. Any encoding that is not a defined byte or
  // halfword access for that direction is treated as a word access.
  function automatic lsu_size_e access_size(input logic is_store,
                                            input logic [2:0] funct3);
    lsu_size_e size;
    size = SIZE_W;
    if (is_store) begin
      if (funct3 == F3_B)      size = SIZE_B;
      else if (funct3 == F3_H) size = SIZE_H;
    end else begin
      if (funct3 == F3_B || funct3 == F3_BU)      size = SIZE_B;
      else if (funct3 == F3_H || funct3 == F3_HU) size = SIZE_H;
    end
    return size;
  endfunction

  // Natural alignment check on the low address bits.
  function automatic logic addr_misaligned(input lsu_size_e size,
                                           input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SIZE_H:  mis = addr_lo[0];
      SIZE_W:  mis = |addr_lo;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: picks the byte/halfword lane addressed by the low
// address bits and sign- or zero-extends it to a full register value.
module lsu_load_align
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane selection and extension; undefined encodings pass the word through.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    byte_lane = rdata[{addr_lo, 3'b000} +: 8];
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    data      = rdata;
    case (funct3)
      F3_B:    data = {{(XLEN-8){byte_lane[7]}}, byte_lane};
      F3_BU:   data = {{(XLEN-8){1'b0}}, byte_lane};
      F3_H:    data = {{(XLEN-16){half_lane[15]}}, half_lane};
      F3_HU:   data = {{(XLEN-16){1'b0}}, half_lane};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/core_lsu.sv
// Load/store unit downstream of EX. Issues one data-memory transaction at a
// time over a req/gnt/rvalid interface, stalls the pipeline while it is in
// flight and returns extended load data to WB.
module core_lsu
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  input  logic [6:0]      i_opcode,
  input  logic [2:0]      i_funct3,
  input  logic [4:0]      i_rd,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_store_data,
  output logic            o_stall,
  output logic            o_dmem_req,
  output logic            o_dmem_we,
  output logic [XLEN-1:0] o_dmem_addr,
  output logic [3:0]      o_dmem_be,
  output logic [XLEN-1:0] o_dmem_wdata,
  input  logic            i_dmem_gnt,
  input  logic            i_dmem_rvalid,
  input  logic [XLEN-1:0] i_dmem_rdata,
  output logic            o_load_valid,
  output logic [XLEN-1:0] o_load_data,
  output logic [4:0]      o_load_rd,
  output logic            o_misaligned
);

  lsu_state_e state_q, state_d;

  logic            is_store;
  logic            mem_op;
  logic            misaligned;
  logic            accept;
  logic            load_done;
  lsu_size_e       size;
  logic [3:0]      be_d;
  logic [XLEN-1:0] wdata_d;

  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [3:0]      be_q;
  logic            we_q;
  logic [2:0]      funct3_q;
  logic [4:0]      rd_q;

  logic            load_valid_q;
  logic [XLEN-1:0] load_data_q;
  logic [4:0]      load_rd_q;
  logic            misaligned_q;
  logic [XLEN-1:0] align_data;

  // Decode the EX/MEM instruction and check natural alignment.
  always_comb begin
    is_store   = (i_opcode == OPCODE_STORE);
    mem_op     = i_valid & ((i_opcode == OPCODE_LOAD) | is_store);
    size       = access_size(is_store, i_funct3);
    misaligned = addr_misaligned(size, i_addr[1:0]);
  end

  // Store formatting: byte enables and lane-replicated write data.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = i_store_data;
    if (is_store) begin
      case (size)
        SIZE_B: begin
          be_d    = 4'b0001 << i_addr[1:0];
          wdata_d = {4{i_store_data[7:0]}};
        end
        SIZE_H: begin
          be_d    = i_addr[1] ? 4'b1100 : 4'b0011;
          wdata_d = {2{i_store_data[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state, request and stall. Stall drops in the rvalid cycle so the
  // pipeline advances on the same edge the unit returns to IDLE.
  always_comb begin
    state_d    = state_q;
    o_stall    = 1'b0;
    o_dmem_req = 1'b0;
    accept     = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op && !misaligned) begin
          accept  = 1'b1;
          o_stall = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        o_dmem_req = 1'b1;
        o_stall    = 1'b1;
        if (i_dmem_gnt) state_d = RESP;
      end
      RESP: begin
        o_stall = !i_dmem_rvalid;
        if (i_dmem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture the transaction fields when a request is accepted; they stay
  // stable on the memory interface until the next accepted access.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      we_q     <= 1'b0;
      funct3_q <= '0;
      rd_q     <= '0;
    end else if (accept) begin
      addr_q   <= i_addr;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      we_q     <= is_store;
      funct3_q <= i_funct3;
      rd_q     <= i_rd;
    end
  end

  lsu_load_align #(
    .XLEN (XLEN)
  ) u_load_align (
    .rdata   (i_dmem_rdata),
    .addr_lo (addr_q[1:0]),
    .funct3  (funct3_q),
    .data    (align_data)
  );

  assign load_done = (state_q == RESP) && i_dmem_rvalid && !we_q;

  // Register the load result and the misaligned pulse for WB.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      load_valid_q <= 1'b0;
      load_data_q  <= '0;
      load_rd_q    <= '0;
      misaligned_q <= 1'b0;
    end else begin
      load_valid_q <= load_done;
      misaligned_q <= (state_q == IDLE) && mem_op && misaligned;
      if (load_done) begin
        load_data_q <= align_data;
        load_rd_q   <= rd_q;
      end
    end
  end

  assign o_dmem_we    = we_q;
  assign o_dmem_addr  = {addr_q[XLEN-1:2], 2'b00};
  assign o_dmem_be    = be_q;
  assign o_dmem_wdata = wdata_q;
  assign o_load_valid = load_valid_q;
  assign o_load_data  = load_data_q;
  assign o_load_rd    = load_rd_q;
  assign o_misaligned = misaligned_q;

endmodule

// File: tb/tb_core_lsu.sv
// Self-checking bench for core_lsu: directed scenarios plus randomized
// accesses checked against an arithmetic model of the access rules.
module tb_core_lsu;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ADD   = 7'b0110011;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic [6:0]  i_opcode = '0;
  logic [2:0]  i_funct3 = '0;
  logic [4:0]  i_rd = '0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_store_data = '0;
  logic        o_stall;
  logic        o_dmem_req;
  logic        o_dmem_we;
  logic [31:0] o_dmem_addr;
  logic [3:0]  o_dmem_be;
  logic [31:0] o_dmem_wdata;
  logic        i_dmem_gnt = 1'b0;
  logic        i_dmem_rvalid = 1'b0;
  logic [31:0] i_dmem_rdata = '0;
  logic        o_load_valid;
  logic [31:0] o_load_data;
  logic [4:0]  o_load_rd;
  logic        o_misaligned;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected load result for the next sampled cycle.
  bit          pend_valid = 1'b0;
  logic [31:0] pend_data = '0;
  logic [4:0]  pend_rd = '0;

  core_lsu #(.XLEN(32)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_valid       (i_valid),
    .i_opcode      (i_opcode),
    .i_funct3      (i_funct3),
    .i_rd          (i_rd),
    .i_addr        (i_addr),
    .i_store_data  (i_store_data),
    .o_stall       (o_stall),
    .o_dmem_req    (o_dmem_req),
    .o_dmem_we     (o_dmem_we),
    .o_dmem_addr   (o_dmem_addr),
    .o_dmem_be     (o_dmem_be),
    .o_dmem_wdata  (o_dmem_wdata),
    .i_dmem_gnt    (i_dmem_gnt),
    .i_dmem_rvalid (i_dmem_rvalid),
    .i_dmem_rdata  (i_dmem_rdata),
    .o_load_valid  (o_load_valid),
    .o_load_data   (o_load_data),
    .o_load_rd     (o_load_rd),
    .o_misaligned  (o_misaligned)
  );

  always #5 i_clk = ~i_clk;

  // ---------------- reference model ----------------
  function automatic int size_bytes(input bit st, input logic [2:0] f3);
    if (st) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    return (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
  endfunction

  function automatic bit model_misaligned(input bit st, input logic [2:0] f3, input logic [31:0] a);
    return (a % size_bytes(st, f3)) != 0;
  endfunction

  function automatic logic [3:0] model_be(input bit st, input logic [2:0] f3, input logic [31:0] a);
    int n;
    if (!st) return 4'hF;
    n = size_bytes(st, f3);
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (size_bytes(1'b1, f3))
      1:       return (d & 32'hFF) * 32'h0101_0101;
      2:       return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rdata);
    int n;
    logic [31:0] v, mask;
    n = size_bytes(1'b0, f3);
    v = rdata >> (8 * (a % 4));
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    v = v & mask;
    if ((f3 == 3'd0 || f3 == 3'd1) && v[8 * n - 1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- scenario tasks ----------------
  // Compares WB-side outputs against the pending expectation (called at negedge).
  task automatic check_pending(input string tag);
    n_cmp++;
    if (o_load_valid !== pend_valid ||
        (pend_valid && (o_load_data !== pend_data || o_load_rd !== pend_rd))) begin
      n_bad++;
      $display("FAIL %s load_result: valid=%b data=%h rd=%0d, required valid=%b data=%h rd=%0d",
               tag, o_load_valid, o_load_data, o_load_rd, pend_valid, pend_data, pend_rd);
    end
    pend_valid = 1'b0;
  endtask

  // Full aligned access. Called and returns at posedge+1. With chain set the
  // instruction stays valid so the caller can present the next one at once.
  task automatic run_access(input bit st, input logic [2:0] f3, input logic [4:0] rd,
                            input logic [31:0] a, input logic [31:0] d,
                            input int gnt_dly, input int rv_dly,
                            input logic [31:0] rdata, input bit chain, input string tag);
    int stalls;
    logic [31:0] exp_addr, exp_wd;
    logic [3:0]  exp_be;
    stalls   = 0;
    exp_addr = a & 32'hFFFF_FFFC;
    exp_be   = model_be(st, f3, a);
    exp_wd   = model_wdata(f3, d);
    i_valid = 1'b1; i_opcode = st ? OP_STORE : OP_LOAD; i_funct3 = f3;
    i_rd = rd; i_addr = a; i_store_data = d;
    @(negedge i_clk);
    check_pending(tag);
    n_cmp++;
    if (o_stall !== 1'b1 || o_dmem_req !== 1'b0 || o_misaligned !== 1'b0) begin
      n_bad++;
      $display("FAIL %s accept: stall=%b req=%b mis=%b, required 1 0 0", tag, o_stall, o_dmem_req, o_misaligned);
    end
    if (o_stall === 1'b1) stalls++;
    @(posedge i_clk); #1;
    for (int k = 0; k <= gnt_dly; k++) begin
      i_dmem_gnt = (k == gnt_dly);
      @(negedge i_clk);
      check_pending(tag);
      n_cmp++;
      if (o_dmem_req !== 1'b1 || o_stall !== 1'b1 || o_dmem_we !== st ||
          o_dmem_addr !== exp_addr || o_dmem_be !== exp_be || (st && o_dmem_wdata !== exp_wd)) begin
        n_bad++;
        $display("FAIL %s request: req=%b stall=%b we=%b addr=%h be=%b wdata=%h, required 1 1 %b %h %b %h",
                 tag, o_dmem_req, o_stall, o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata,
                 st, exp_addr, exp_be, exp_wd);
      end
      if (o_stall === 1'b1) stalls++;
      @(posedge i_clk); #1;
    end
    i_dmem_gnt = 1'b0;
    for (int k = 0; k <= rv_dly; k++) begin
      i_dmem_rvalid = (k == rv_dly);
      i_dmem_rdata  = (k == rv_dly) ? rdata : $urandom;
      @(negedge i_clk);
      check_pending(tag);
      n_cmp++;
      if (o_dmem_req !== 1'b0 || o_stall !== (k != rv_dly)) begin
        n_bad++;
        $display("FAIL %s response: req=%b stall=%b, required 0 %b", tag, o_dmem_req, o_stall, k != rv_dly);
      end
      if (o_stall === 1'b1) stalls++;
      @(posedge i_clk); #1;
    end
    i_dmem_rvalid = 1'b0;
    i_dmem_rdata  = $urandom;
    if (!chain) i_valid = 1'b0;
    if (!st) begin
      pend_valid = 1'b1;
      pend_data  = model_load(f3, a, rdata);
      pend_rd    = rd;
    end
    n_cmp++;
    if (stalls != 2 + gnt_dly + rv_dly) begin
      n_bad++;
      $display("FAIL %s stall_cycles: got %0d, required %0d", tag, stalls, 2 + gnt_dly + rv_dly);
    end
  endtask

  // One idle cycle: no stall, no request, pending result checked.
  task automatic idle_cycle(input string tag);
    @(negedge i_clk);
    check_pending(tag);
    n_cmp++;
    if (o_stall !== 1'b0 || o_dmem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL %s idle: stall=%b req=%b, required 0 0", tag, o_stall, o_dmem_req);
    end
    @(posedge i_clk); #1;
  endtask

  task automatic run_misaligned(input bit st, input logic [2:0] f3, input logic [31:0] a,
                                input string tag);
    int pulses;
    pulses = 0;
    i_valid = 1'b1; i_opcode = st ? OP_STORE : OP_LOAD; i_funct3 = f3;
    i_rd = 5'($urandom); i_addr = a; i_store_data = $urandom;
    @(negedge i_clk);
    check_pending(tag);
    n_cmp++;
    if (o_stall !== 1'b0 || o_dmem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL %s mis_stall: stall=%b req=%b, required 0 0", tag, o_stall, o_dmem_req);
    end
    if (o_misaligned === 1'b1) pulses++;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge i_clk);
      if (o_misaligned === 1'b1) pulses++;
      n_cmp++;
      if (o_misaligned !== (k == 0) || o_dmem_req !== 1'b0 || o_stall !== 1'b0) begin
        n_bad++;
        $display("FAIL %s mis_pulse[%0d]: mis=%b req=%b stall=%b, required %b 0 0",
                 tag, k, o_misaligned, o_dmem_req, o_stall, k == 0);
      end
      @(posedge i_clk); #1;
    end
    n_cmp++;
    if (pulses != 1) begin
      n_bad++;
      $display("FAIL %s mis_count: got %0d pulses, required 1", tag, pulses);
    end
  endtask

  task automatic check_all_zero(input string tag);
    n_cmp++;
    if ({o_stall, o_dmem_req, o_dmem_we, o_load_valid, o_misaligned} !== 5'b0 ||
        o_dmem_addr !== 32'h0 || o_dmem_be !== 4'h0 || o_dmem_wdata !== 32'h0 ||
        o_load_data !== 32'h0 || o_load_rd !== 5'h0) begin
      n_bad++;
      $display("FAIL %s reset_outputs: stall=%b req=%b we=%b lv=%b mis=%b addr=%h be=%b wd=%h ld=%h rd=%0d, required all 0",
               tag, o_stall, o_dmem_req, o_dmem_we, o_load_valid, o_misaligned,
               o_dmem_addr, o_dmem_be, o_dmem_wdata, o_load_data, o_load_rd);
    end
  endtask

  task automatic test_reset();
    #2;
    check_all_zero("reset");
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    idle_cycle("post_reset");
  endtask

  task automatic test_store_byte();
    run_access(1'b1, 3'b000, 5'd0, 32'h0000_1003, 32'h0000_00A5, 0, 1, 32'h0, 1'b0, "sb");
    idle_cycle("sb_done");
  endtask

  task automatic test_load_extend();
    run_access(1'b0, 3'b001, 5'd5, 32'h0000_2002, 32'h0, 0, 0, 32'h8001_1234, 1'b0, "lh");
    run_access(1'b0, 3'b101, 5'd6, 32'h0000_2002, 32'h0, 0, 0, 32'h8001_1234, 1'b0, "lhu");
    run_access(1'b0, 3'b000, 5'd7, 32'h0000_2001, 32'h0, 1, 0, 32'h0000_9A00, 1'b0, "lb");
    idle_cycle("lb_done");
  endtask

  task automatic test_wait_states();
    run_access(1'b0, 3'b010, 5'd19, 32'h0000_3000, 32'h0, 4, 2, 32'hCAFE_F00D, 1'b0, "lw_wait");
    idle_cycle("lw_wait_done");
  endtask

  task automatic test_misaligned();
    run_misaligned(1'b0, 3'b010, 32'h0000_3002, "lw_mis");
    run_misaligned(1'b1, 3'b001, 32'h0000_3001, "sh_mis");
  endtask

  task automatic test_reset_in_resp();
    i_valid = 1'b1; i_opcode = OP_LOAD; i_funct3 = 3'b010; i_rd = 5'd9; i_addr = 32'h0000_4444;
    @(posedge i_clk); #1;
    i_dmem_gnt = 1'b1;
    @(posedge i_clk); #1;
    i_dmem_gnt = 1'b0;
    #2;
    i_valid = 1'b0;
    i_rst_n = 1'b0;
    #1;
    check_all_zero("rst_in_resp");
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    i_dmem_rvalid = 1'b1;
    i_dmem_rdata  = 32'h1234_5678;
    idle_cycle("stray_rvalid");
    i_dmem_rvalid = 1'b0;
    idle_cycle("stray_rvalid_after");
    check_all_zero("stray_rvalid_zero");
    run_access(1'b0, 3'b100, 5'd3, 32'h0000_5003, 32'h0, 0, 0, 32'hF000_0000, 1'b0, "lbu_after_rst");
    idle_cycle("lbu_after_rst_done");
  endtask

  task automatic test_back_to_back();
    run_access(1'b1, 3'b010, 5'd0, 32'h0000_6000, 32'hDEAD_BEEF, 0, 0, 32'h0, 1'b1, "b2b_sw");
    run_access(1'b0, 3'b010, 5'd12, 32'h0000_6004, 32'h0, 0, 0, 32'h0BAD_CAFE, 1'b1, "b2b_lw");
    i_valid = 1'b1; i_opcode = OP_ADD; i_funct3 = 3'b000; i_addr = 32'h0000_0003;
    i_rd = 5'd1;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      check_pending("add");
      n_cmp++;
      if (o_stall !== 1'b0 || o_dmem_req !== 1'b0 || o_misaligned !== 1'b0) begin
        n_bad++;
        $display("FAIL add[%0d]: stall=%b req=%b mis=%b, required 0 0 0", k, o_stall, o_dmem_req, o_misaligned);
      end
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
  endtask

  task automatic test_random();
    bit          st;
    logic [2:0]  f3;
    logic [31:0] a;
    for (int i = 0; i < 40; i++) begin
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom);
      a  = $urandom & 32'h0000_FFFF;
      if (model_misaligned(st, f3, a))
        run_misaligned(st, f3, a, "rnd_mis");
      else
        run_access(st, f3, 5'($urandom), a, $urandom, $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)), "rnd");
    end
    i_valid = 1'b0;
    idle_cycle("rnd_done");
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_load_extend();
    test_wait_states();
    test_misaligned();
    test_reset_in_resp();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
